dram_responder: RTL

- Synthesizable clocked model of an FPM DRAM (MT4LC16M4T8-style, 8-bit data) that sits on the far side of the RAS/CAS/WE/address bus driven by the SIMM controller.
- Samples the registered strobes every clock, decodes read, early-write and CBR-refresh cycles, and serves data from a small on-chip memory.
- Checks protocol timing in clock cycles and reports sticky error flags and a refresh counter.
- Used in simulation and on the board as a loopback target, so controller sequencing can be verified without a physical SIMM.

---
 rtl/dram_responder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dram_responder.sv
// dram_responder: clocked FPM DRAM model that serves as a loopback target for the
// SIMM controller. It samples RAS/CAS/WE every clock, decodes read, early-write
// and CBR-refresh cycles, stores bytes in a small aliased memory, and flags
// protocol timing violations.
//
// Ports:
//   clk            system clock, strobes sampled on rising edge
//   rst            synchronous active-high reset
//   ram_addr[11:0] multiplexed row/column address
//   ram_we_        write enable (active low)
//   ram_ras_       row strobe (active low)
//   ram_cas_       column strobe (active low)
//   dq_in[7:0]     write data
//   dq_out[7:0]    read data, holds its last value while dq_oe is low
//   dq_oe          high while dq_out carries read data
//   refresh_count  completed CBR refreshes (wraps)
//   err_flags[3:0] sticky errors: [0] refresh overdue, [1] tRP, [2] tRAS, [3] page mode
//   ref_armed      high once the first CBR refresh has completed
module dram_responder #(
  parameter int ROW_KEEP    = 4,
  parameter int COL_KEEP    = 6,
  parameter int CAS_LAT     = 1,
  parameter int TRP_MIN     = 5,
  parameter int TRAS_MIN    = 4,
  parameter int REFRESH_MAX = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ram_addr,
  input  logic        ram_we_,
  input  logic        ram_ras_,
  input  logic        ram_cas_,
  input  logic [7:0]  dq_in,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic [15:0] refresh_count,
  output logic [3:0]  err_flags,
  output logic        ref_armed
);

  localparam int AW = ROW_KEEP + COL_KEEP;
  localparam int TW = $clog2(REFRESH_MAX + 2);
  localparam logic [TW-1:0] REF_LIMIT = TW'(REFRESH_MAX + 1);
  localparam logic [7:0] TRP_LIM  = 8'(TRP_MIN);
  localparam logic [7:0] TRAS_LIM = 8'(TRAS_MIN);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_CBR_PEND, S_CBR, S_PRE
  } state_t;

  state_t state_q, state_d;

  logic [7:0] mem [2**AW];

  logic ras_p, cas_p, ras_ok, cas_ok;
  logic ras_fall, ras_rise, cas_fall, cas_rise;

  logic [ROW_KEEP-1:0] row_q;
  logic                page_q;
  logic [7:0]          hi_cnt, lo_cnt;
  logic                first_done;
  logic [TW-1:0]       ref_timer;

  logic [7:0]          pipe_d [CAS_LAT];
  logic [CAS_LAT-1:0]  pipe_v;
  logic                oe_hold;

  logic          row_load, acc_go, page_err, tras_chk, refresh_done;
  logic          wr_fire, rd_fire;
  logic [AW-1:0] acc_addr;

  logic unused_addr;
  assign unused_addr = ^ram_addr;

  // ras_ok/cas_ok stay low after reset until the strobe is seen high, so a
  // strobe still low from before reset cannot produce a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_p  <= 1'b1;
      cas_p  <= 1'b1;
      ras_ok <= 1'b0;
      cas_ok <= 1'b0;
    end else begin
      ras_p  <= ram_ras_;
      cas_p  <= ram_cas_;
      ras_ok <= ras_ok | ram_ras_;
      cas_ok <= cas_ok | ram_cas_;
    end
  end

  assign ras_fall = ras_ok & ras_p & ~ram_ras_;
  assign cas_fall = cas_ok & cas_p & ~ram_cas_;
  assign ras_rise = ~ras_p & ram_ras_;
  assign cas_rise = ~cas_p & ram_cas_;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    row_load     = 1'b0;
    acc_go       = 1'b0;
    acc_addr     = {row_q, ram_addr[COL_KEEP-1:0]};
    page_err     = 1'b0;
    tras_chk     = 1'b0;
    refresh_done = 1'b0;
    case (state_q)
      S_IDLE, S_PRE: begin
        if (ras_fall && cas_fall) begin
          // Row and column both come from this cycle's address.
          state_d  = S_COL;
          row_load = 1'b1;
          acc_go   = 1'b1;
          acc_addr = {ram_addr[ROW_KEEP-1:0], ram_addr[COL_KEEP-1:0]};
        end else if (ras_fall && ram_cas_) begin
          state_d  = S_ROW;
          row_load = 1'b1;
        end else if (cas_fall && ram_ras_) begin
          state_d = S_CBR_PEND;
        end
      end
      S_ROW: begin
        if (ras_rise) begin
          state_d  = S_PRE;
          tras_chk = 1'b1;
        end else if (cas_fall) begin
          state_d  = S_COL;
          acc_go   = 1'b1;
          page_err = page_q;
        end
      end
      S_COL: begin
        if (ras_rise) begin
          state_d  = S_PRE;
          tras_chk = 1'b1;
        end else if (cas_rise) begin
          state_d = S_ROW;
        end
      end
      S_CBR_PEND: begin
        if (ras_fall)      state_d = S_CBR;
        else if (cas_rise) state_d = S_IDLE;
      end
      S_CBR: begin
        if (ras_rise) begin
          state_d      = S_PRE;
          tras_chk     = 1'b1;
          refresh_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_fire = acc_go & ~ram_we_;
    rd_fire = acc_go & ram_we_;
  end

  // Writes are gated by rst so a write sampled during reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem[acc_addr] <= dq_in;
  end

  // Read pipeline: stage 0 is the registered memory read; later stages only
  // load when valid data arrives, so the output holds between reads. dq_oe is
  // kept up by oe_hold until CAS rises, even if RAS rose first.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v  <= '0;
      oe_hold <= 1'b0;
      for (int unsigned i = 0; i < CAS_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_fire;
      if (rd_fire) pipe_d[0] <= mem[acc_addr];
      for (int unsigned i = 1; i < CAS_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
      if (cas_rise) begin
        pipe_v  <= '0;
        oe_hold <= 1'b0;
      end else begin
        oe_hold <= oe_hold | pipe_v[CAS_LAT-1];
      end
    end
  end

  assign dq_out = pipe_d[CAS_LAT-1];
  assign dq_oe  = pipe_v[CAS_LAT-1] | oe_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q         <= '0;
      page_q        <= 1'b0;
      hi_cnt        <= '0;
      lo_cnt        <= '0;
      first_done    <= 1'b0;
      ref_timer     <= '0;
      refresh_count <= '0;
      ref_armed     <= 1'b0;
      err_flags     <= '0;
    end else begin
      if (row_load) row_q <= ram_addr[ROW_KEEP-1:0];
      if (acc_go)        page_q <= 1'b1;
      else if (row_load) page_q <= 1'b0;

      if (ras_rise)                         hi_cnt <= 8'd1;
      else if (ram_ras_ && hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 8'd1;
      if (ras_fall)                          lo_cnt <= 8'd1;
      else if (!ram_ras_ && lo_cnt != 8'hFF) lo_cnt <= lo_cnt + 8'd1;

      if (ras_fall) begin
        first_done <= 1'b1;
        if (first_done && hi_cnt < TRP_LIM) err_flags[1] <= 1'b1;
      end
      if (tras_chk && lo_cnt < TRAS_LIM) err_flags[2] <= 1'b1;
      if (page_err) err_flags[3] <= 1'b1;

      if (refresh_done) begin
        refresh_count <= refresh_count + 16'd1;
        ref_armed     <= 1'b1;
        ref_timer     <= '0;
      end else if (ref_armed && ref_timer != REF_LIMIT) begin
        ref_timer <= ref_timer + TW'(1);
        if (ref_timer + TW'(1) == REF_LIMIT) err_flags[0] <= 1'b1;
      end
    end
  end

endmodule
